// File: rtl/vecmat_pkg.sv
// rtl/vecmat_pkg.sv - shared constants, state encoding and helpers for the vecmat packer
package vecmat_pkg;

  localparam int EW         = 16;
  localparam int VARRAYSIZE = 1600;
  localparam int VECTWIDTH  = 100;

  // Counter must represent 0..n inclusive, since a full vector's length is n.
  function automatic int vec_lenw(input int n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } pack_state_t;

endpackage

// File: rtl/vecmat_slot_writer.sv
// rtl/vecmat_slot_writer.sv - assembly register with indexed element write and synchronous clear
module vecmat_slot_writer
  import vecmat_pkg::*;
#(
  parameter int NSLOT = VECTWIDTH,
  parameter int IDXW  = vec_lenw(VECTWIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic [IDXW-1:0]       i_wr_idx,
  input  logic [EW-1:0]         i_wr_data,
  output logic [NSLOT*EW-1:0]   o_data,
  output logic [NSLOT*EW-1:0]   o_merged
);

  logic [NSLOT*EW-1:0] r_data;
  logic [NSLOT*EW-1:0] w_merged;

  // Merged view lets the top capture a completing vector including the element
  // being written on this same edge.
  always_comb begin
    w_merged = r_data;
    for (int i = 0; i < NSLOT; i++) begin
      if (i_wr_en && (i_wr_idx == IDXW'(i))) begin
        w_merged[i*EW +: EW] = i_wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_clr) begin
      r_data <= '0;
    end else if (i_wr_en) begin
      r_data <= w_merged;
    end
  end

  assign o_data   = r_data;
  assign o_merged = w_merged;

endmodule

// File: rtl/vecmat_vec_packer.sv
// rtl/vecmat_vec_packer.sv - collects serial 16-bit elements into a packed vector with
// a skid-free assembly/output register pair
module vecmat_vec_packer
  import vecmat_pkg::*;
#(
  parameter int varraysize = VARRAYSIZE,
  parameter int vectwidth  = VECTWIDTH,
  parameter int LENW       = vec_lenw(vectwidth)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EW-1:0]         in_data,
  input  logic                  in_last,
  output logic                  vec_valid,
  input  logic                  vec_ready,
  output logic [varraysize-1:0] vec_data,
  output logic [LENW-1:0]       vec_len
);

  pack_state_t           r_state;
  pack_state_t           w_state_nxt;
  logic [LENW-1:0]       r_cnt;
  logic                  r_vec_valid;
  logic [varraysize-1:0] r_vec_data;
  logic [LENW-1:0]       r_vec_len;

  logic                  w_accept;
  logic                  w_complete;
  logic                  w_out_free;
  logic                  w_load_direct;
  logic                  w_load_held;
  logic                  w_clr;
  logic [varraysize-1:0] w_asm;
  logic [varraysize-1:0] w_merged;

  assign w_accept      = in_valid && (r_state == ST_FILL);
  assign w_complete    = w_accept && (in_last || (r_cnt == LENW'(vectwidth - 1)));
  assign w_out_free    = !r_vec_valid || vec_ready;
  assign w_load_direct = w_complete && w_out_free;
  assign w_load_held   = (r_state == ST_HOLD) && r_vec_valid && vec_ready;
  assign w_clr         = w_load_direct || w_load_held;

  vecmat_slot_writer #(
    .NSLOT (vectwidth),
    .IDXW  (LENW)
  ) u_slot_writer (
    .clk       (clk),
    .rst_n     (reset),
    .i_clr     (w_clr),
    .i_wr_en   (w_accept),
    .i_wr_idx  (r_cnt),
    .i_wr_data (in_data),
    .o_data    (w_asm),
    .o_merged  (w_merged)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: if (w_complete && !w_out_free) w_state_nxt = ST_HOLD;
      ST_HOLD: if (w_load_held)               w_state_nxt = ST_FILL;
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // While in HOLD the counter already holds the pending vector length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_clr) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + LENW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vec_valid <= 1'b0;
      r_vec_data  <= '0;
      r_vec_len   <= '0;
    end else if (w_load_direct) begin
      r_vec_valid <= 1'b1;
      r_vec_data  <= w_merged;
      r_vec_len   <= r_cnt + LENW'(1);
    end else if (w_load_held) begin
      r_vec_valid <= 1'b1;
      r_vec_data  <= w_asm;
      r_vec_len   <= r_cnt;
    end else if (r_vec_valid && vec_ready) begin
      r_vec_valid <= 1'b0;
    end
  end

  assign in_ready  = (r_state == ST_FILL);
  assign vec_valid = r_vec_valid;
  assign vec_data  = r_vec_data;
  assign vec_len   = r_vec_len;

endmodule

// File: tb/tb_vecmat_vec_packer.sv
// tb/tb_vecmat_vec_packer.sv - directed self-checking bench for vecmat_vec_packer
module tb_vecmat_vec_packer;

  localparam int VW   = 1600;
  localparam int NV   = 100;
  localparam int LENW = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_data;
  logic            in_last;
  logic            vec_valid;
  logic            vec_ready;
  logic [VW-1:0]   vec_data;
  logic [LENW-1:0] vec_len;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vecmat_vec_packer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .vec_len   (vec_len)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] slot(input int i);
    return vec_data[i*16 +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_vec(input logic [15:0] base, input logic [15:0] step, input int n, input logic last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 16'(i) * step;
      in_last  = last && (i == n - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  int pulses;
  int first_pulse;
  int second_pulse;
  int ready_drops;

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    vec_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    check("rst_vec_valid", 64'(vec_valid), 64'd0);
    check("rst_vec_len",   64'(vec_len),   64'd0);
    check("rst_vec_data",  64'(|vec_data), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);

    // full vector 1..100, consumer always ready
    vec_ready = 1'b1;
    send_vec(16'h0001, 16'h0001, 100, 1'b0);
    check("full_valid", 64'(vec_valid), 64'd1);
    check("full_slot0", 64'(slot(0)),   64'h0001);
    check("full_slot99", 64'(slot(99)), 64'h0064);
    check("full_len",   64'(vec_len),   64'd100);
    tick();
    check("full_drop",  64'(vec_valid), 64'd0);

    // short vector terminated by in_last
    send_one(16'hAAAA, 1'b0);
    send_one(16'hBBBB, 1'b0);
    send_one(16'hCCCC, 1'b1);
    check("short_valid", 64'(vec_valid),      64'd1);
    check("short_len",   64'(vec_len),        64'd3);
    check("short_lo",    64'(vec_data[47:0]), 64'hCCCC_BBBB_AAAA);
    check("short_hi0",   64'(|vec_data[VW-1:48]), 64'd0);
    tick();

    // backpressure: A presented, B waits in the assembly register
    vec_ready = 1'b0;
    send_vec(16'h1000, 16'h0001, 100, 1'b0);
    check("bp_a_valid", 64'(vec_valid), 64'd1);
    check("bp_a_ready", 64'(in_ready),  64'd1);
    send_vec(16'h2000, 16'h0001, 100, 1'b0);
    check("bp_hold_ready", 64'(in_ready), 64'd0);
    check("bp_hold_a0",   64'(slot(0)),  64'h1000);
    check("bp_hold_a99",  64'(slot(99)), 64'h1063);
    tick();
    check("bp_hold_stable", 64'(slot(5)), 64'h1005);
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    check("bp_b_valid", 64'(vec_valid), 64'd1);
    check("bp_b0",      64'(slot(0)),   64'h2000);
    check("bp_b99",     64'(slot(99)),  64'h2063);
    check("bp_b_len",   64'(vec_len),   64'd100);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    vec_ready = 1'b1;
    tick();
    check("bp_b_drop", 64'(vec_valid), 64'd0);

    // back-to-back full vectors, in_valid held high
    pulses = 0; first_pulse = -1; second_pulse = -1; ready_drops = 0;
    for (int cyc = 0; cyc < 210; cyc++) begin
      in_valid = (cyc < 200);
      in_data  = 16'h4000 + 16'(cyc % 100);
      if (cyc < 200 && !in_ready) ready_drops++;
      tick();
      if (vec_valid) begin
        pulses++;
        if (first_pulse < 0) first_pulse = cyc;
        else if (second_pulse < 0) second_pulse = cyc;
      end
    end
    in_valid = 1'b0;
    check("b2b_pulses",  64'(pulses),      64'd2);
    check("b2b_first",   64'(first_pulse), 64'd99);
    check("b2b_spacing", 64'(second_pulse - first_pulse), 64'd100);
    check("b2b_ready",   64'(ready_drops), 64'd0);

    // async reset mid-vector with a vector still presented
    vec_ready = 1'b0;
    send_one(16'h5555, 1'b1);
    check("ar_pre_valid", 64'(vec_valid), 64'd1);
    send_vec(16'h6000, 16'h0001, 50, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check("ar_valid", 64'(vec_valid), 64'd0);
    check("ar_data",  64'(|vec_data), 64'd0);
    check("ar_len",   64'(vec_len),   64'd0);
    tick();
    tick();
    reset = 1'b1;
    send_vec(16'hFFFF, 16'h0000, 100, 1'b0);
    check("ar_new_valid", 64'(vec_valid), 64'd1);
    check("ar_new_ones",  64'(&vec_data), 64'd1);
    check("ar_new_len",   64'(vec_len),   64'd100);

    // in_last on element 100 coinciding with the output handshake
    send_vec(16'h3000, 16'h0001, 99, 1'b0);
    check("hs_prev_held", 64'(&vec_data), 64'd1);
    in_valid  = 1'b1;
    in_data   = 16'h3063;
    in_last   = 1'b1;
    vec_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    vec_ready = 1'b0;
    check("hs_valid", 64'(vec_valid), 64'd1);
    check("hs_s0",    64'(slot(0)),   64'h3000);
    check("hs_s99",   64'(slot(99)),  64'h3063);
    check("hs_len",   64'(vec_len),   64'd100);
    check("hs_ready", 64'(in_ready),  64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
